// File: rtl/refill_cache_instrucoes.sv
// Refill controller for the direct-mapped instruction cache: on a miss it fetches the
// four words of the missing line from instruction memory and writes the whole line back.
module refill_cache_instrucoes #(
  parameter int TAG_BITS   = 24,
  parameter int INDEX_BITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss,
  input  logic [31:0]           PC,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  fill_valid,
  output logic [INDEX_BITS-1:0] fill_index,
  output logic [TAG_BITS-1:0]   fill_tag,
  output logic [127:0]          fill_data,
  output logic                  refill_busy,
  output logic [15:0]           refill_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic [TAG_BITS-1:0]     tag_q, tag_d;
  logic [INDEX_BITS-1:0]   index_q, index_d;
  logic [TAG_BITS-1:0]     fill_tag_q, fill_tag_d;
  logic [INDEX_BITS-1:0]   fill_index_q, fill_index_d;
  logic [127:0]            fill_data_q, fill_data_d;
  logic [15:0]             refill_count_q, refill_count_d;
  logic [31:0]             word_q [0:2];
  logic                    accept;
  logic                    pc_offset_unused;

  // The line is always fetched from word 0, so the byte/word offset of PC is irrelevant.
  assign pc_offset_unused = ^PC[3:0];

  assign accept = (state_q == S_FETCH) && mem_ready;

  // Words 0..2 are buffered; word 3 goes straight into the fill line on the last accept.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_word
      always_ff @(posedge clock) begin
        if (!reset) begin
          word_q[gi] <= '0;
        end else if (accept && (k_q == 2'(gi))) begin
          word_q[gi] <= mem_rdata;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    tag_d          = tag_q;
    index_d        = index_q;
    fill_tag_d     = fill_tag_q;
    fill_index_d   = fill_index_q;
    fill_data_d    = fill_data_q;
    refill_count_d = refill_count_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          tag_d   = PC[31 -: TAG_BITS];
          index_d = PC[4 +: INDEX_BITS];
          k_d     = 2'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            fill_data_d  = {mem_rdata, word_q[2], word_q[1], word_q[0]};
            fill_tag_d   = tag_q;
            fill_index_d = index_q;
            state_d      = S_FILL;
          end
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
        if (refill_count_q != 16'hFFFF) begin
          refill_count_d = refill_count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      k_q            <= 2'd0;
      tag_q          <= '0;
      index_q        <= '0;
      fill_tag_q     <= '0;
      fill_index_q   <= '0;
      fill_data_q    <= '0;
      refill_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      tag_q          <= tag_d;
      index_q        <= index_d;
      fill_tag_q     <= fill_tag_d;
      fill_index_q   <= fill_index_d;
      fill_data_q    <= fill_data_d;
      refill_count_q <= refill_count_d;
    end
  end

  assign mem_req      = (state_q == S_FETCH);
  assign mem_addr     = {tag_q, index_q, k_q, 2'b00};
  assign fill_valid   = (state_q == S_FILL);
  assign fill_tag     = fill_tag_q;
  assign fill_index   = fill_index_q;
  assign fill_data    = fill_data_q;
  assign refill_busy  = (state_q != S_IDLE);
  assign refill_count = refill_count_q;

endmodule

// File: tb/tb_refill_cache_instrucoes.sv
// Scoreboard bench for the instruction-cache refill controller: stimulus pushes expected
// memory addresses and fills, a negedge monitor pops and compares them.
module tb_refill_cache_instrucoes;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         miss = 1'b0;
  logic [31:0]  PC = '0;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b0;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [3:0]   fill_index;
  logic [23:0]  fill_tag;
  logic [127:0] fill_data;
  logic         refill_busy;
  logic [15:0]  refill_count;

  refill_cache_instrucoes #(.TAG_BITS(24), .INDEX_BITS(4)) dut (
    .clock(clock), .reset(reset), .miss(miss), .PC(PC),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_data(fill_data), .refill_busy(refill_busy), .refill_count(refill_count)
  );

  typedef struct {
    logic [23:0]  tag;
    logic [3:0]   idx;
    logic [127:0] data;
    int           e0;
  } fill_t;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          fills_seen = 0;
  int          accepts = 0;
  int          stalls = 0;
  logic [15:0] exp_count = 16'd0;
  logic [31:0] salt = 32'd0;
  logic [31:0] addr_q [$];
  fill_t       fill_q [$];
  fill_t       mon_e;

  // Instruction memory contents: a fixed scramble of the address, re-salted per refill.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign mem_rdata = mem_word(mem_addr, salt);

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (mem_req) begin
        if (addr_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_req: mem_addr=%h with no word outstanding", mem_addr);
        end else if (mem_ready) begin
          chk("mem_addr", 128'(mem_addr), 128'(addr_q[0]));
          void'(addr_q.pop_front());
          accepts++;
        end else begin
          chk("mem_addr_hold", 128'(mem_addr), 128'(addr_q[0]));
          stalls++;
        end
      end
      if (fill_valid) begin
        if (fill_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_fill: index=%h tag=%h", fill_index, fill_tag);
        end else begin
          mon_e = fill_q.pop_front();
          chk("fill_tag", 128'(fill_tag), 128'(mon_e.tag));
          chk("fill_index", 128'(fill_index), 128'(mon_e.idx));
          chk("fill_data", fill_data, mon_e.data);
          chk("fill_cycle", 128'(cyc), 128'(mon_e.e0 + 4 + stalls));
          $display("fill idx=%0d tag=%h data=%h at cycle %0d", fill_index, fill_tag, fill_data, cyc);
          if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
        end
        stalls = 0;
        fills_seen++;
      end
    end
  end

  task automatic push_expect(input logic [31:0] pc);
    logic [31:0]  a;
    logic [127:0] d;
    fill_t        e;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      a = {pc[31:4], 4'b0000} + 32'(4 * k);
      addr_q.push_back(a);
      d[32*k +: 32] = mem_word(a, salt);
    end
    e.tag  = pc[31:8];
    e.idx  = pc[7:4];
    e.data = d;
    e.e0   = cyc + 1;
    fill_q.push_back(e);
  endtask

  // mode: 0 zero-wait, 1 two waits before word 2, 2 random waits.
  // pcchg: 0 PC held, 1 PC moved to DEADBEE0, 2 PC and miss randomised during the refill.
  task automatic do_refill(input logic [31:0] pc, input int mode, input int pcchg);
    int start, acc0, sd, n;
    start = fills_seen;
    acc0  = accepts;
    sd    = 0;
    n     = 0;
    salt  = $urandom();
    push_expect(pc);
    miss      = 1'b1;
    PC        = pc;
    mem_ready = 1'b1;
    while (fills_seen == start && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (fills_seen == start) begin
        chk("busy_refill", 128'(refill_busy), 128'(1'b1));
        if (pcchg == 1) PC = 32'hDEAD_BEE0;
        else if (pcchg == 2) begin
          PC   = $urandom();
          miss = 1'($urandom_range(0, 1));
        end
        if (mode == 1) begin
          if ((accepts - acc0) == 2 && sd < 2) begin
            mem_ready = 1'b0;
            sd++;
          end else begin
            mem_ready = 1'b1;
          end
        end else if (mode == 2) begin
          mem_ready = ($urandom_range(0, 3) != 0);
        end else begin
          mem_ready = 1'b1;
        end
      end
    end
    miss      = 1'b0;
    mem_ready = 1'b1;
    if (fills_seen == start) begin
      compared++;
      mismatched++;
      $display("FAIL refill_timeout: no fill for PC %h within 100 cycles", pc);
      addr_q.delete();
      fill_q.delete();
      stalls = 0;
      reset  = 1'b0;
      @(posedge clock);
      #1;
      reset     = 1'b1;
      exp_count = 16'd0;
    end else begin
      chk("refill_count", 128'(refill_count), 128'(exp_count));
      chk("busy_idle", 128'(refill_busy), 128'(1'b0));
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_fill_valid", 128'(fill_valid), 128'(0));
    chk("rst_fill_index", 128'(fill_index), 128'(0));
    chk("rst_fill_tag", 128'(fill_tag), 128'(0));
    chk("rst_fill_data", fill_data, 128'(0));
    chk("rst_busy", 128'(refill_busy), 128'(0));
    chk("rst_count", 128'(refill_count), 128'(0));
    reset = 1'b1;
    @(posedge clock);
    #1;

    do_refill(32'h0000_1234, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    do_refill(32'h0000_1234, 1, 0);
    do_refill(32'h0000_1234, 0, 1);
    do_refill(32'h0000_0040, 0, 0);
    do_refill(32'h0000_0F80, 0, 0);
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("idle_no_retrigger", 128'(mem_req), 128'(0));
    end

    // Abandon a refill after two words have been accepted.
    salt = $urandom();
    push_expect(32'h0000_5670);
    miss      = 1'b1;
    PC        = 32'h0000_5670;
    mem_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    miss  = 1'b0;
    @(posedge clock);
    #1;
    addr_q.delete();
    fill_q.delete();
    stalls    = 0;
    exp_count = 16'd0;
    chk("rstmid_mem_req", 128'(mem_req), 128'(0));
    chk("rstmid_busy", 128'(refill_busy), 128'(0));
    chk("rstmid_count", 128'(refill_count), 128'(0));
    reset = 1'b1;
    repeat (4) begin
      @(posedge clock);
      #1;
      chk("rstmid_idle_req", 128'(mem_req), 128'(0));
    end

    for (int i = 0; i < 30; i++) begin
      do_refill($urandom(), 2, 2);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        #1;
        chk("gap_mem_req", 128'(mem_req), 128'(0));
      end
    end

    // Preload the counter near its ceiling instead of running 65 535 refills.
    @(negedge clock);
    force dut.refill_count_q = 16'hFFFE;
    @(posedge clock);
    #1;
    release dut.refill_count_q;
    exp_count = 16'hFFFE;
    chk("sat_preload", 128'(refill_count), 128'(16'hFFFE));
    do_refill($urandom(), 0, 0);
    do_refill($urandom(), 2, 0);
    do_refill($urandom(), 1, 0);
    chk("sat_hold", 128'(refill_count), 128'(16'hFFFF));

    repeat (5) @(posedge clock);
    #1;
    chk("end_addr_q_empty", 128'(addr_q.size()), 128'(0));
    chk("end_fill_q_empty", 128'(fill_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
